sphere_discriminant_unit: RTL and testbench
===========================================

Name: sphere_discriminant_unit

Overview:
- Producer stage feeding the sphere distance calculator.
- Takes the ray/sphere quadratic coefficients B and C (a = 1 form) and computes disc = B*B − 4*C.
- Flags a quick hit when disc ≥ 0 and computes floor(sqrt(disc)) with an iterative bit-per-cycle root.
- Presents RootDiscriminant, B, QuickIntersects and OldDistance to the distance calculator through a valid/ready handshake.

Parameters:
- ROOT_W, 24, root width in bits; disc is saturated to 2*ROOT_W bits; iteration count = ROOT_W.

Ports:
- CLK  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- InValid  in  1  upstream coefficients valid
- InReady  out  1  block can accept; high only in IDLE
- BIn  in  32  signed B coefficient
- CIn  in  32  signed C coefficient (|OC|² − r²)
- OldDistanceIn  in  32  current closest distance, passed through
- OutValid  out  1  result valid; drives the distance calculator's InputValid
- OutReady  in  1  downstream ready; driven by the distance calculator's InputReady
- RootDiscriminant  out  ROOT_W  floor(sqrt(disc)); 0 when disc < 0
- BOut  out  32  signed B, registered copy of BIn
- QuickIntersects  out  1  1 when disc ≥ 0
- OldDistanceOut  out  32  registered copy of OldDistanceIn

Behaviour:
- Reset (aresetn=0 at a CLK edge):
  - state → IDLE.
  - OutValid, RootDiscriminant, BOut, QuickIntersects and OldDistanceOut → 0.
  - InReady = 1 from the first cycle after reset.
  - Reset mid-operation discards the transaction. No partial output.
- States: IDLE, CALC, ROOT, HOLD. InReady = (state==IDLE). OutValid = (state==HOLD).
- IDLE:
  - On an edge with InValid=1, latch BIn, CIn and OldDistanceIn, then go to CALC.
  - Otherwise stay in IDLE.
- CALC (1 cycle):
  - disc = BIn*BIn − 4*CIn, evaluated at full signed 66-bit width with no overflow.
  - If disc < 0: QuickIntersects←0, RootDiscriminant←0, go to HOLD.
  - If disc ≥ 0: QuickIntersects←1. Saturate disc to 2^(2*ROOT_W)−1 when it is larger. Clear the remainder, root and counter. Go to ROOT.
- ROOT (exactly ROOT_W cycles):
  - Restoring digit-by-digit root, one result bit per cycle, MSB first.
  - Counter runs 0..ROOT_W−1.
  - On the edge where the counter = ROOT_W−1, write the final root to RootDiscriminant and go to HOLD.
  - The final root is floor(sqrt(sat_disc)). The saturated case yields 2^ROOT_W−1.
- HOLD:
  - OutValid=1. BOut, OldDistanceOut, QuickIntersects and RootDiscriminant are stable.
  - On an edge with OutReady=1, the transfer completes and the state goes to IDLE.
  - OutReady=0 holds every output indefinitely.
  - Outputs keep their last values after leaving HOLD.
- Latency, counted in CLK edges from the accept edge to the first cycle with OutValid=1:
  - ROOT_W+2 edges for disc ≥ 0 (26 at the default ROOT_W).
  - 2 edges for disc < 0.
- Throughput: one transaction in flight. InValid is ignored outside IDLE. The earliest next accept is the edge after the HOLD transfer.
- OutReady is ignored outside HOLD.
- Simultaneous OutReady transfer and InValid on the same edge: only the transfer occurs. The new input is accepted from IDLE on a later edge.
- BOut is sign-preserving, so the downstream (−B ± root)>>1 stays correct.
- Widths: B*B is 64 bits unsigned. 4*C is 34 bits signed. The root register is ROOT_W bits. The remainder is ROOT_W+2 bits.

Test Plan:
- Reset: hold aresetn=0 for 3 cycles, then release. Required: all outputs 0 and InReady=1. Then BIn=−10, CIn=9, OldDistanceIn=100 with OutReady=1. Required: QuickIntersects=1, RootDiscriminant=8, BOut=−10 and OldDistanceOut=100, with OutValid rising 26 edges after the accept.
- BIn=4, CIn=5 (disc=−4). Required: OutValid 2 edges after accept, QuickIntersects=0, RootDiscriminant=0.
- Tangent case BIn=0, CIn=0. Required: QuickIntersects=1, RootDiscriminant=0. Non-square case BIn=−7, CIn=3 (disc=37). Required: RootDiscriminant=6.
- Saturation: BIn=2^30, CIn=0 (disc=2^60). Required: RootDiscriminant=16777215. Also BIn=−2^31, CIn=−2^31. Required: no overflow and RootDiscriminant=16777215.
- Backpressure: hold OutReady=0 for 10 cycles in HOLD. Required: OutValid and all outputs stable and InReady=0. Also pulse InValid during ROOT. Required: the pulse is ignored. Then raise OutReady. Required: a single transfer, with InReady=1 on the next cycle.
- Reset mid-ROOT: assert aresetn=0 at iteration 10. Required: IDLE, outputs 0, no OutValid. Then a fresh transaction with BIn=−10, CIn=9 must return RootDiscriminant=8.

Source files
------------

// File: rtl/sphere_discriminant_unit.sv
// Ray/sphere discriminant stage: disc = B*B - 4*C, quick-hit flag and floor(sqrt(disc))
// computed one root bit per cycle, handed downstream through a valid/ready handshake.
module sphere_discriminant_unit #(
    parameter int ROOT_W = 24
) (
    input  logic              CLK,
    input  logic              aresetn,
    input  logic              InValid,
    output logic              InReady,
    input  logic [31:0]       BIn,
    input  logic [31:0]       CIn,
    input  logic [31:0]       OldDistanceIn,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [ROOT_W-1:0] RootDiscriminant,
    output logic [31:0]       BOut,
    output logic              QuickIntersects,
    output logic [31:0]       OldDistanceOut
);
    localparam int DW = 2 * ROOT_W;
    localparam int CW = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, ROOT, HOLD} state_t;

    state_t            state_q, state_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       c_q, c_d;
    logic [31:0]       old_q, old_d;
    logic              qi_q, qi_d;
    logic [ROOT_W-1:0] root_out_q, root_out_d;
    logic [DW-1:0]     disc_q, disc_d;
    logic [ROOT_W+1:0] rem_q, rem_d;
    logic [ROOT_W-1:0] root_q, root_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [31:0]        b_mag;
    logic [63:0]        b_sq;
    logic signed [65:0] disc_full;
    logic [DW-1:0]      disc_sat;
    logic [ROOT_W+3:0]  rem_sh;
    logic [ROOT_W+3:0]  trial;
    logic               trial_ok;
    logic [ROOT_W-1:0]  root_step;

    always_comb begin
        // B*B taken from |B| so the square is an exact unsigned 64-bit value
        b_mag     = b_q[31] ? (~b_q + 32'd1) : b_q;
        b_sq      = {32'd0, b_mag} * {32'd0, b_mag};
        disc_full = $signed({2'b00, b_sq}) - $signed({{32{c_q[31]}}, c_q, 2'b00});
        disc_sat  = (|disc_full[65:DW]) ? {DW{1'b1}} : disc_full[DW-1:0];

        rem_sh    = {rem_q, disc_q[DW-1 -: 2]};
        trial     = {2'b00, root_q, 2'b01};
        trial_ok  = (rem_sh >= trial);
        root_step = {root_q[ROOT_W-2:0], trial_ok};
    end

    always_comb begin
        state_d    = state_q;
        b_d        = b_q;
        c_d        = c_q;
        old_d      = old_q;
        qi_d       = qi_q;
        root_out_d = root_out_q;
        disc_d     = disc_q;
        rem_d      = rem_q;
        root_d     = root_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                if (InValid) begin
                    b_d     = BIn;
                    c_d     = CIn;
                    old_d   = OldDistanceIn;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (disc_full[65]) begin
                    qi_d       = 1'b0;
                    root_out_d = '0;
                    state_d    = HOLD;
                end else begin
                    qi_d    = 1'b1;
                    disc_d  = disc_sat;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = '0;
                    state_d = ROOT;
                end
            end
            ROOT: begin
                disc_d = disc_q << 2;
                rem_d  = trial_ok ? (rem_sh[ROOT_W+1:0] - trial[ROOT_W+1:0]) : rem_sh[ROOT_W+1:0];
                root_d = root_step;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(ROOT_W - 1)) begin
                    root_out_d = root_step;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (OutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            b_q        <= '0;
            c_q        <= '0;
            old_q      <= '0;
            qi_q       <= 1'b0;
            root_out_q <= '0;
            disc_q     <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            b_q        <= b_d;
            c_q        <= c_d;
            old_q      <= old_d;
            qi_q       <= qi_d;
            root_out_q <= root_out_d;
            disc_q     <= disc_d;
            rem_q      <= rem_d;
            root_q     <= root_d;
            cnt_q      <= cnt_d;
        end
    end

    assign InReady          = (state_q == IDLE);
    assign OutValid         = (state_q == HOLD);
    assign RootDiscriminant = root_out_q;
    assign BOut             = b_q;
    assign QuickIntersects  = qi_q;
    assign OldDistanceOut   = old_q;

endmodule

// File: tb/tb_sphere_discriminant_unit.sv
// Bench for sphere_discriminant_unit: directed corner cases plus random coefficients,
// checked against an integer reference model of the discriminant and its square root.
module tb_sphere_discriminant_unit;
    localparam int ROOT_W = 24;

    logic              CLK = 1'b0;
    logic              aresetn = 1'b0;
    logic              InValid = 1'b0;
    logic              OutReady = 1'b1;
    logic [31:0]       BIn = '0;
    logic [31:0]       CIn = '0;
    logic [31:0]       OldDistanceIn = '0;
    logic              InReady;
    logic              OutValid;
    logic [ROOT_W-1:0] RootDiscriminant;
    logic [31:0]       BOut;
    logic              QuickIntersects;
    logic [31:0]       OldDistanceOut;

    sphere_discriminant_unit #(.ROOT_W(ROOT_W)) dut (
        .CLK(CLK), .aresetn(aresetn), .InValid(InValid), .InReady(InReady),
        .BIn(BIn), .CIn(CIn), .OldDistanceIn(OldDistanceIn),
        .OutValid(OutValid), .OutReady(OutReady),
        .RootDiscriminant(RootDiscriminant), .BOut(BOut),
        .QuickIntersects(QuickIntersects), .OldDistanceOut(OldDistanceOut)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0]       b;
        logic [31:0]       od;
        logic              qi;
        logic [ROOT_W-1:0] root;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: exact integer discriminant, clamp, then largest r with r*r <= disc.
    task automatic model(input logic [31:0] b, input logic [31:0] c,
                         output logic qi, output logic [ROOT_W-1:0] r);
        longint d;
        longint sat;
        longint acc;
        longint cand;
        d = longint'($signed(b)) * longint'($signed(b)) - 4 * longint'($signed(c));
        if (d < 0) begin
            qi = 1'b0;
            r  = '0;
        end else begin
            qi  = 1'b1;
            sat = (d > ((64'sd1 <<< (2*ROOT_W)) - 1)) ? ((64'sd1 <<< (2*ROOT_W)) - 1) : d;
            acc = 0;
            for (int bit_i = ROOT_W - 1; bit_i >= 0; bit_i--) begin
                cand = acc + (64'sd1 <<< bit_i);
                if (cand * cand <= sat) acc = cand;
            end
            r = acc[ROOT_W-1:0];
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Compare process: every cycle with OutValid the outputs must equal the head of the queue.
    always @(negedge CLK) begin
        if (aresetn && OutValid) begin
            if (expq.size() == 0) begin
                chk("unexpected_outvalid", 64'(OutValid), 64'(0));
            end else begin
                chk("root", 64'(RootDiscriminant), 64'(expq[0].root));
                chk("quick_intersects", 64'(QuickIntersects), 64'(expq[0].qi));
                chk("bout", 64'(BOut), 64'(expq[0].b));
                chk("old_distance", 64'(OldDistanceOut), 64'(expq[0].od));
                if (OutReady) void'(expq.pop_front());
            end
        end
    end

    task automatic txn(input logic [31:0] b, input logic [31:0] c, input logic [31:0] od,
                       input int stall, input bit pulse, input bit overlap);
        exp_t e;
        logic qi;
        logic [ROOT_W-1:0] r;
        int n;
        int w;
        w = 0;
        while (!InReady && w < 100) begin
            tick();
            w++;
        end
        if (!InReady) begin
            chk("inready_timeout", 64'(InReady), 64'(1));
            return;
        end
        model(b, c, qi, r);
        e.b = b; e.od = od; e.qi = qi; e.root = r;
        expq.push_back(e);
        BIn = b; CIn = c; OldDistanceIn = od;
        InValid  = 1'b1;
        OutReady = (stall == 0);
        tick();
        n = 1;
        InValid = 1'b0;
        BIn = $urandom; CIn = $urandom; OldDistanceIn = $urandom;
        while (!OutValid && n < 100) begin
            InValid = (pulse && n == 5);
            if (pulse) chk("inready_busy", 64'(InReady), 64'(0));
            tick();
            n++;
        end
        InValid = 1'b0;
        chk("latency", 64'(n), qi ? 64'(ROOT_W + 2) : 64'(2));
        for (int k = 0; k < stall; k++) begin
            chk("hold_valid", {62'd0, OutValid, InReady}, 64'd2);
            tick();
        end
        chk("pre_transfer_valid", 64'(OutValid), 64'(1));
        OutReady = 1'b1;
        if (overlap) begin
            InValid = 1'b1;
            BIn = $urandom; CIn = $urandom; OldDistanceIn = $urandom;
        end
        tick();
        chk("post_transfer", {62'd0, OutValid, InReady}, 64'd1);
        if (overlap) begin
            InValid = 1'b0;
            tick();
            chk("overlap_not_accepted", 64'(InReady), 64'(1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic              mqi;
        logic [ROOT_W-1:0] mr;
        logic [31:0]       rb;
        logic [31:0]       rc;
        int                sb;
        int                mode;
        int                seen_valid;

        // Pin the model to hand-computed values.
        model(-32'sd10, 32'sd9, mqi, mr);
        chk("model_m10_9", {mqi, 40'd0, mr}, {1'b1, 40'd0, 24'd8});
        model(32'd4, 32'd5, mqi, mr);
        chk("model_4_5", {mqi, 40'd0, mr}, {1'b0, 40'd0, 24'd0});
        model(-32'sd7, 32'sd3, mqi, mr);
        chk("model_m7_3", 64'(mr), 64'(6));
        model(32'h4000_0000, 32'd0, mqi, mr);
        chk("model_sat", 64'(mr), 64'(16777215));

        aresetn = 1'b0;
        repeat (3) tick();
        aresetn = 1'b1;
        chk("reset_outvalid", 64'(OutValid), 64'(0));
        chk("reset_inready", 64'(InReady), 64'(1));
        chk("reset_root", 64'(RootDiscriminant), 64'(0));
        chk("reset_bout", 64'(BOut), 64'(0));
        chk("reset_qi", 64'(QuickIntersects), 64'(0));
        chk("reset_old", 64'(OldDistanceOut), 64'(0));

        txn(-32'sd10, 32'sd9, 32'd100, 0, 0, 0);
        txn(32'd4, 32'd5, 32'd200, 0, 0, 0);
        txn(32'd0, 32'd0, 32'd300, 0, 0, 0);
        txn(-32'sd7, 32'sd3, 32'd400, 0, 0, 0);
        txn(32'h4000_0000, 32'd0, 32'd500, 0, 0, 0);
        txn(32'h8000_0000, 32'h8000_0000, 32'd600, 0, 0, 0);
        txn(-32'sd7, 32'sd3, 32'd55, 10, 1, 0);
        txn(32'd4, 32'd5, 32'd7, 3, 0, 1);

        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 2));
            sb   = int'($urandom_range(0, 4000)) - 2000;
            rb   = sb;
            if (mode == 0) begin
                rc = int'($urandom_range(0, 2000000)) - 1000000;
            end else if (mode == 1) begin
                rb = $urandom;
                rc = $urandom;
            end else begin
                rc = (sb * sb) / 4 + int'($urandom_range(0, 4)) - 2;
            end
            txn(rb, rc, $urandom, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)));
        end

        // Reset during the root iterations must drop the transaction.
        BIn = 32'h4000_0000; CIn = 32'd0; OldDistanceIn = 32'd99;
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        repeat (11) tick();
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        expq.delete();
        chk("midreset_inready", 64'(InReady), 64'(1));
        chk("midreset_outs", {RootDiscriminant, QuickIntersects, OutValid},
            64'(0));
        chk("midreset_bout_old", {BOut, OldDistanceOut}, 64'(0));
        seen_valid = 0;
        repeat (30) begin
            if (OutValid) seen_valid++;
            tick();
        end
        chk("midreset_no_outvalid", 64'(seen_valid), 64'(0));
        txn(-32'sd10, 32'sd9, 32'd100, 0, 0, 0);

        repeat (3) tick();
        chk("queue_drained", 64'(expq.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
